// File: rtl/ser8_sequencer_pkg.sv
// Shared constants for the byte-to-bit sequencer: FSM encoding and word geometry.
package ser8_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam int         BITS_PER_WORD = 8;
  localparam logic [2:0] LAST_BEAT     = 3'(BITS_PER_WORD - 1);

endpackage

// File: rtl/ser8_sequencer_mux8.sv
// 8:1 bit selector fed by the sequencer; a..h are data bits 0..7.
module mux_8 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       h,
  input  logic [2:0] sel,
  output logic       y
);

  always_comb begin
    unique case (sel)
      3'd0:    y = a;
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      3'd5:    y = f;
      3'd6:    y = g;
      default: y = h;
    endcase
  end

endmodule

// File: rtl/ser8_sequencer.sv
// Parallel-to-serial front end: accepts a byte per handshake and walks the
// mux_8 select through all eight bits with valid/ready/last backpressure.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | no word held; load_ready=1, ser_valid=0
//   SEND    | word in flight; ser_valid=1, sel steps on each beat
module ser8_sequencer
  import ser8_sequencer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  output logic [7:0] word_q,
  output logic [2:0] sel,
  output logic       ser_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_last,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] word_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       load_acc;
  logic       beat_acc;

  assign ser_valid  = (state_q == ST_SEND);
  assign busy       = ser_valid;
  assign ser_last   = ser_valid && (cnt_q == LAST_BEAT);
  // Only the last beat lets ser_ready reach load_ready, enabling gapless words.
  assign load_ready = !ser_valid || (ser_last && ser_ready);
  assign load_acc   = load_valid && load_ready;
  assign beat_acc   = ser_valid && ser_ready;
  assign sel        = sel_q;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    word_d      = word_q;
    frame_cnt_d = frame_cnt_q;
    if (beat_acc) begin
      cnt_d = cnt_q + 3'd1;
      // The 3-bit wrap on the last beat lands sel back on SEL_START.
      sel_d = MSB_FIRST ? 3'(3'd6 - cnt_q) : 3'(cnt_q + 3'd1);
      if (ser_last) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = ST_IDLE;
      end
    end
    if (load_acc) begin
      word_d  = load_data;
      cnt_d   = 3'd0;
      sel_d   = SEL_START;
      state_d = ST_SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      sel_q       <= SEL_START;
      word_q      <= 8'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      word_q      <= word_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  mux_8 u_mux (
    .a   (word_q[0]),
    .b   (word_q[1]),
    .c   (word_q[2]),
    .d   (word_q[3]),
    .e   (word_q[4]),
    .f   (word_q[5]),
    .g   (word_q[6]),
    .h   (word_q[7]),
    .sel (sel_q),
    .y   (ser_out)
  );

endmodule

// File: tb/tb_ser8_sequencer.sv
// Bench for ser8_sequencer: one LSB-first and one MSB-first instance on shared stimulus.
module tb_ser8_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_ready;

  logic       lr0, sv0, last0, busy0, out0;
  logic [7:0] wq0, fc0;
  logic [2:0] sel0;
  logic       lr1, sv1, last1, busy1, out1;
  logic [7:0] wq1, fc1;
  logic [2:0] sel1;

  int checks = 0;
  int errors = 0;

  // Reference: a word in flight is just (word, beat index k); bit order follows from k.
  logic       m_busy;
  logic [7:0] m_word;
  int         m_k;
  int         m_frames;

  ser8_sequencer #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr0),
    .load_data(load_data), .word_q(wq0), .sel(sel0), .ser_out(out0),
    .ser_valid(sv0), .ser_ready(ser_ready), .ser_last(last0), .busy(busy0),
    .frame_cnt(fc0)
  );

  ser8_sequencer #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr1),
    .load_data(load_data), .word_q(wq1), .sel(sel1), .ser_out(out1),
    .ser_valid(sv1), .ser_ready(ser_ready), .ser_last(last1), .busy(busy1),
    .frame_cnt(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       sr;
    logic       lr;
    logic       sv;
    logic       last;
    logic [2:0] s0;
    logic       o0;
    logic [2:0] s1;
    logic       o1;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_word   = 8'd0;
    m_k      = 0;
    m_frames = 0;
  endtask

  task automatic check_all();
    int       lsb_idx;
    int       msb_idx;
    logic     exp_lr;
    lsb_idx = m_busy ? m_k : 0;
    msb_idx = m_busy ? 7 - m_k : 7;
    exp_lr  = !m_busy || (m_k == 7 && ser_ready);
    chk("load_ready", 8'(lr0), 8'(exp_lr));
    chk("ser_valid", 8'(sv0), 8'(m_busy));
    chk("busy", 8'(busy0), 8'(m_busy));
    chk("ser_last", 8'(last0), 8'(m_busy && m_k == 7));
    chk("sel_lsb", 8'(sel0), 8'(lsb_idx));
    chk("ser_out_lsb", 8'(out0), 8'(m_word[lsb_idx]));
    chk("word_q", wq0, m_word);
    chk("frame_cnt", fc0, 8'(m_frames % 256));
    chk("load_ready_msb", 8'(lr1), 8'(exp_lr));
    chk("ser_last_msb", 8'(last1), 8'(m_busy && m_k == 7));
    chk("sel_msb", 8'(sel1), 8'(msb_idx));
    chk("ser_out_msb", 8'(out1), 8'(m_word[msb_idx]));
    chk("frame_cnt_msb", fc1, 8'(m_frames % 256));
  endtask

  // One clock cycle: drive at the falling edge, check, advance model across the rising edge.
  task automatic step(input logic lv, input logic [7:0] ld, input logic sr);
    logic lr_e, beat, load;
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    #1;
    check_all();
    lr_e = !m_busy || (m_k == 7 && sr);
    beat = m_busy && sr;
    load = lv && lr_e;
    if (beat) begin
      if (m_k == 7) begin
        m_frames = m_frames + 1;
        m_busy   = 1'b0;
        m_k      = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
    if (load) begin
      m_busy = 1'b1;
      m_word = ld;
      m_k    = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int vcount;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'd0;
    ser_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-word: load 0x5A, take four beats, then assert reset.
    step(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    chk("rst_mid_valid", 8'(sv0), 8'd0);
    chk("rst_mid_sel", 8'(sel0), 8'd0);
    chk("rst_mid_frames", fc0, 8'd0);
    step(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

    // Table-driven 0xA5 word, LSB and MSB instances side by side.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 3'd6, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 3'd5, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 3'd4, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 3'd3, 1'b0, 8'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 3'd2, 1'b1, 8'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 3'd1, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 8'd0};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 8'd1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      load_valid = tbl[i].lv;
      load_data  = tbl[i].ld;
      ser_ready  = tbl[i].sr;
      #1;
      chk("tbl_load_ready", 8'(lr0), 8'(tbl[i].lr));
      chk("tbl_ser_valid", 8'(sv0), 8'(tbl[i].sv));
      chk("tbl_ser_last", 8'(last0), 8'(tbl[i].last));
      chk("tbl_sel_lsb", 8'(sel0), 8'(tbl[i].s0));
      chk("tbl_out_lsb", 8'(out0), 8'(tbl[i].o0));
      chk("tbl_sel_msb", 8'(sel1), 8'(tbl[i].s1));
      chk("tbl_out_msb", 8'(out1), 8'(tbl[i].o1));
      chk("tbl_frame_cnt", fc0, tbl[i].fc);
      @(posedge clk);
      @(negedge clk);
    end

    // 0x80: MSB-first instance sends 1 then seven 0s.
    do_reset();
    step(1'b1, 8'h80, 1'b1);
    chk("msb_first_bit", 8'(out1), 8'd1);
    chk("msb_first_sel", 8'(sel1), 8'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    // 0xFF then 0x00 with load_valid held: 16 gapless valid beats.
    step(1'b1, 8'hFF, 1'b1);
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      if (sv0) vcount++;
      step(i < 8, (i < 7) ? 8'hFF : 8'h00, 1'b1);
    end
    chk("b2b_valid_beats", 8'(vcount), 8'd16);
    chk("b2b_frames", fc0, 8'd3);

    // 0x3C with a 5-cycle stall at beat 3.
    step(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hE7, 1'b0);
      chk("stall_sel", 8'(sel0), 8'd3);
      chk("stall_out", 8'(out0), 8'd1);
      chk("stall_word", wq0, 8'h3C);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

    // Random handshake traffic against the reference.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));

    // 256 back-to-back words wrap frame_cnt to 0.
    do_reset();
    for (int i = 0; i < 256 * 8; i++) step(1'b1, 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("frame_wrap", fc0, 8'd0);
    chk("frame_wrap_idle", 8'(sv0), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
